pixel_write_queue: RTL and testbench
====================================

# pixel_write_queue

Buffering stage between the drawing engines (dash, gallows, body-part, fill and clear drawers) and the VGA adapter. It accepts packed pixel coordinates plus a 3-bit colour over a valid/ready handshake and stores them in a small FIFO. It drains at most one pixel per clock to the adapter's write port, asserting a one-cycle plot strobe per pixel. It also reports primitive completion back to control via a `done` pulse.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 4.
- `AW`, 4: log2(DEPTH); must match `DEPTH`.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer offers a pixel.
- `in_ready`  out  1  queue can accept; equals not-full.
- `in_xy`  in  15  packed pixel, `{x[7:0], y[6:0]}`.
- `in_color`  in  3  colour (`111` white, `001` blue, `010` green, `100` red, `000` black).
- `in_last`  in  1  marks the final pixel of a primitive.
- `hold`  in  1  pauses draining while high; filling continues.
- `vga_x`  out  8  x coordinate to the adapter.
- `vga_y`  out  7  y coordinate to the adapter.
- `vga_colour`  out  3  colour to the adapter.
- `vga_plot`  out  1  write strobe, one cycle per pixel.
- `done`  out  1  one-cycle pulse when the last pixel of a primitive is issued.
- `level`  out  AW+1  current occupancy, 0..DEPTH.

## Operation
- **Storage.** Each entry is 19 bits: xy[15], color[3], last[1]. Write and read pointers are AW bits wide and wrap modulo DEPTH. Occupancy is held in a separate AW+1-bit counter.
- **Push.** A push occurs when `in_valid && in_ready`. The entry is written at the write pointer and the write pointer increments.
- **Pop.** A pop occurs when `level != 0 && !hold`. The entry at the read pointer is loaded into the output registers and the read pointer increments.
- **Output registers.** `vga_x`, `vga_y`, `vga_colour` and `vga_plot` are registered.
  - On a pop cycle: `vga_plot` is 1 and `done` equals the entry's last bit.
  - On any other cycle: `vga_plot` and `done` are 0. `vga_x`, `vga_y` and `vga_colour` hold their last value.
- **Occupancy.** `level` is +1 on push only, −1 on pop only, and unchanged on both or neither.
- **Full.** `in_ready` is 0 whenever `level == DEPTH`, even if a pop happens in the same cycle. There is no combinational path from the pop to `in_ready`.
- **Empty.** There is no bypass. A pixel pushed into an empty queue cannot pop in the same cycle.
- **Ordering.** Strict FIFO order. Pixels are never merged, reordered or dropped.
- **Hold.** While `hold` is high, nothing pops. Pushes continue until full. Releasing `hold` resumes draining on the next edge.
- **Reset.** Reset is asynchronous and can occur mid-operation. It clears both pointers, `level`, `vga_x`, `vga_y`, `vga_colour`, `vga_plot` and `done` to 0, and all queued pixels are discarded. `in_ready` reads 1 during and after reset. Storage RAM contents need not be cleared.

## Timing
- **Latency.** A pixel accepted at edge N into an empty, un-held queue has `vga_plot=1` with its coordinates valid after edge N+1.
- **Throughput.** Sustained 1 pixel per clock when `hold` is low.
- **Pulse width.** `done` and `vga_plot` are single-cycle pulses, aligned to the same edge.
- **Back-to-back primitives.** `in_last` on consecutive pixels produces consecutive `done` pulses.
- **Wrap-around.** Pointer wrap is invisible at the ports. After 3·DEPTH pushes and pops, order and data are preserved.

## Configuration
- **Macro:** `PIXEL_CLIP_EN`.
- **Defined.** At pop time, an entry with x ≥ 160 or y ≥ 120 is issued with `vga_plot=0`. It still consumes its pop cycle, still updates `vga_x`, `vga_y` and `vga_colour`, and still raises `done` if its last bit is set. This keeps control's completion count exact.
- **Undefined.** Every popped entry asserts `vga_plot`, regardless of coordinates.

## Test plan
- **Reset state:** assert `resetn=0` mid-stream with `level=5` -> `level=0`, `vga_plot=0`, `done=0` and `in_ready=1` immediately. The next popped pixel is the first one pushed after reset.
- **Single pixel:** push xy=`{8'd100, 7'd20}`, color=`001`, last=1 into an empty queue -> one edge later: `vga_x=100`, `vga_y=20`, `vga_colour=001`, `vga_plot=1`, `done=1`, each for exactly one cycle.
- **Fill under hold:** `hold=1`, offer 20 pixels -> `in_ready` drops after 16 accepts and `level=16`. Release `hold` -> 16 consecutive `vga_plot` cycles in push order, then `in_ready=1`.
- **Wrap and order:** stream 48 pixels with incrementing y (x=30) while toggling `hold` pseudo-randomly -> outputs match a scoreboard exactly. `done` fires only on the pixels tagged `in_last`, which are indices 9, 10 and 47.
- **Simultaneous push/pop:** with `level=3`, push and pop every cycle for 10 cycles -> `level` stays 3 and `vga_plot` is high for all 10 cycles.
- **Clip (PIXEL_CLIP_EN defined):** push (160,0,last=0), then (159,119,last=0), then (0,120,last=1) -> plot pattern 0,1,0. `done=1` on the third pop. Without the macro, the same stimulus gives plot pattern 1,1,1.

Source files
------------

// File: rtl/pixel_write_queue.sv
// pixel_write_queue: FIFO between the drawing engines and the VGA adapter write port.
// Build option `PIXEL_CLIP_EN: off-screen pixels still pop but are issued with vga_plot low.
module pixel_write_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_xy,
  input  logic [2:0]  in_color,
  input  logic        in_last,
  input  logic        hold,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        done,
  output logic [AW:0] level
);

  localparam int          EW   = 19;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // Entry layout: {x[7:0], y[6:0], colour[2:0], last}
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    colour_q, colour_d;
  logic          plot_q, plot_d;
  logic          done_q, done_d;

  logic          push;
  logic          pop;
  logic          visible;
  logic [EW-1:0] rd_entry;

  // Full is judged on the registered level only, so a same-cycle pop never reaches in_ready.
  assign in_ready = (level_q != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (level_q != '0) && !hold;
  assign rd_entry = mem_q[rd_ptr_q];

`ifdef PIXEL_CLIP_EN
  assign visible = (rd_entry[18:11] < 8'd160) && (rd_entry[10:4] < 7'd120);
`else
  assign visible = 1'b1;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      x_d      = rd_entry[18:11];
      y_d      = rd_entry[10:4];
      colour_d = rd_entry[3:1];
      plot_d   = visible;
      done_d   = rd_entry[0];
    end

    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: pixel storage is deliberately left out of reset; pointers and level make stale words unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_xy, in_color, in_last};
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;
  assign done       = done_q;
  assign level      = level_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Self-checking bench for pixel_write_queue: vector table, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_pixel_write_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef PIXEL_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_xy = '0;
  logic [2:0]  in_color = '0;
  logic        in_last = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        done;
  logic [AW:0] level;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  pixel_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_xy      (in_xy),
    .in_color   (in_color),
    .in_last    (in_last),
    .hold       (hold),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .done       (done),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] x, input logic [6:0] y,
                       input logic [2:0] c, input logic l, input logic h);
    in_valid = v;
    in_xy    = {x, y};
    in_color = c;
    in_last  = l;
    hold     = h;
  endtask

  task automatic drain();
    drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4 * DEPTH && level != 0; i++) tick();
    tick();
    check("drain level", 32'(level), 32'd0);
  endtask

  // ---------------- reference model: a pixel queue stepped once per edge ----------------
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       last;
  } pix_t;

  pix_t       mq[$];
  pix_t       m_e;
  bit         m_push, m_pop;
  logic       exp_plot = 1'b0;
  logic       exp_done = 1'b0;
  logic [7:0] exp_x = '0;
  logic [6:0] exp_y = '0;
  logic [2:0] exp_c = '0;

  function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
    if (!CLIP) return 1'b1;
    return (int'(x) < 160) && (int'(y) < 120);
  endfunction

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      mq.delete();
      exp_plot = 1'b0;
      exp_done = 1'b0;
      exp_x    = '0;
      exp_y    = '0;
      exp_c    = '0;
    end else begin
      m_push = in_valid && (mq.size() < DEPTH);
      m_pop  = (mq.size() != 0) && !hold;
      if (m_pop) begin
        m_e      = mq.pop_front();
        exp_x    = m_e.x;
        exp_y    = m_e.y;
        exp_c    = m_e.c;
        exp_plot = on_screen(m_e.x, m_e.y);
        exp_done = m_e.last;
      end else begin
        exp_plot = 1'b0;
        exp_done = 1'b0;
      end
      if (m_push) mq.push_back('{in_xy[14:7], in_xy[6:0], in_color, in_last});
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model level", 32'(level), 32'(mq.size()));
      check("model in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      check("model vga_plot", 32'(vga_plot), 32'(exp_plot));
      check("model done", 32'(done), 32'(exp_done));
      check("model x/y/colour", 32'({vga_x, vga_y, vga_colour}), 32'({exp_x, exp_y, exp_c}));
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       l;
    logic       h;
    logic       e_plot;
    logic       e_done;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
    int         e_level;
  } vec_t;

  vec_t vecs[8];

  int accepts, pops, plotted, dones, idx, cyc;
  logic was_last[48];

  initial begin
    vecs[0] = '{1'b1, 8'd100, 7'd20,  3'b001, 1'b1, 1'b0, 1'b0,  1'b0, 8'd0,   7'd0,   3'b000, 1};
    vecs[1] = '{1'b0, 8'd0,   7'd0,   3'b000, 1'b0, 1'b0, 1'b1,  1'b1, 8'd100, 7'd20,  3'b001, 0};
    vecs[2] = '{1'b0, 8'd0,   7'd0,   3'b000, 1'b0, 1'b0, 1'b0,  1'b0, 8'd100, 7'd20,  3'b001, 0};
    vecs[3] = '{1'b1, 8'd160, 7'd0,   3'b100, 1'b0, 1'b0, 1'b0,  1'b0, 8'd100, 7'd20,  3'b001, 1};
    vecs[4] = '{1'b1, 8'd159, 7'd119, 3'b010, 1'b0, 1'b0, !CLIP, 1'b0, 8'd160, 7'd0,   3'b100, 1};
    vecs[5] = '{1'b1, 8'd0,   7'd120, 3'b111, 1'b1, 1'b0, 1'b1,  1'b0, 8'd159, 7'd119, 3'b010, 1};
    vecs[6] = '{1'b0, 8'd0,   7'd0,   3'b000, 1'b0, 1'b0, !CLIP, 1'b1, 8'd0,   7'd120, 3'b111, 0};
    vecs[7] = '{1'b0, 8'd0,   7'd0,   3'b000, 1'b0, 1'b0, 1'b0,  1'b0, 8'd0,   7'd120, 3'b111, 0};

    // Reset state
    #3 resetn = 1'b0;
    #1;
    check("reset level", 32'(level), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset vga_plot", 32'(vga_plot), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset x/y/colour", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    tick();

    // Single pixel and clip pattern
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].l, vecs[i].h);
      tick();
      check($sformatf("vec%0d plot", i), 32'(vga_plot), 32'(vecs[i].e_plot));
      check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d x/y/colour", i), 32'({vga_x, vga_y, vga_colour}),
            32'({vecs[i].e_x, vecs[i].e_y, vecs[i].e_c}));
      check($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].e_level));
    end

    // Fill under hold, then release
    accepts = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'd50, 7'(i), 3'b010, 1'b0, 1'b1);
      if (in_ready) accepts++;
      tick();
    end
    drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
    check("fill accepts", 32'(accepts), 32'd16);
    check("fill level", 32'(level), 32'd16);
    check("fill in_ready", 32'(in_ready), 32'd0);
    hold = 1'b0;
    pops = 0;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      if (vga_plot && vga_y == 7'(k) && vga_x == 8'd50) pops++;
    end
    check("release consecutive plots", 32'(pops), 32'd16);
    check("release in_ready", 32'(in_ready), 32'd1);
    tick();
    check("release plot ends", 32'(vga_plot), 32'd0);

    // Simultaneous push and pop at level 3
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'd20, 7'(i), 3'b100, 1'b0, 1'b1);
      tick();
    end
    check("simul start level", 32'(level), 32'd3);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'd20, 7'(i + 3), 3'b100, 1'b0, 1'b0);
      tick();
      check($sformatf("simul level c%0d", i), 32'(level), 32'd3);
      check($sformatf("simul plot c%0d", i), 32'(vga_plot), 32'd1);
    end
    drain();

    // Wrap and order with pseudo-random hold
    foreach (was_last[i]) was_last[i] = (i == 9) || (i == 10) || (i == 47);
    idx = 0; plotted = 0; dones = 0; cyc = 0;
    while ((idx < 48 || plotted < 48) && cyc < 2000) begin
      drive(idx < 48, 8'd30, 7'(idx), 3'b111, (idx < 48) ? was_last[idx] : 1'b0,
            (idx < 48) ? ($urandom_range(0, 2) == 0) : 1'b0);
      if (in_valid && in_ready) idx++;
      tick();
      cyc++;
      if (vga_plot) begin
        if (plotted < 48) begin
          check($sformatf("wrap y #%0d", plotted), 32'(vga_y), 32'(plotted));
          check($sformatf("wrap done #%0d", plotted), 32'(done), 32'(was_last[plotted]));
        end
        if (done) dones++;
        plotted++;
      end
    end
    check("wrap plotted count", 32'(plotted), 32'd48);
    check("wrap done count", 32'(dones), 32'd3);
    drain();

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 7'($urandom), 3'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0);
      tick();
    end
    drain();

    // Reset mid-stream at level 5 with a pop in flight
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'd10, 7'(i), 3'b001, i == 0, 1'b1);
      tick();
    end
    drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    tick();
    check("pre-reset plot", 32'(vga_plot), 32'd1);
    check("pre-reset done", 32'(done), 32'd1);
    check("pre-reset level", 32'(level), 32'd5);
    #2 resetn = 1'b0;
    #1;
    check("midreset level", 32'(level), 32'd0);
    check("midreset plot", 32'(vga_plot), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, 8'd7, 7'd7, 3'b010, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    tick();
    check("post-reset plot", 32'(vga_plot), 32'd1);
    check("post-reset first pixel", 32'({vga_x, vga_y, vga_colour}), 32'({8'd7, 7'd7, 3'b010}));
    check("post-reset level", 32'(level), 32'd0);
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
